// File: rtl/conv_puncture_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_puncture_encoder_if : serial data-in / coded-bit-out handshake bundle |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface conv_puncture_encoder_if;
  logic       i_start;
  logic [1:0] i_rate;
  logic       i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_data;
  logic       o_valid;

  modport master (
    output i_start, i_rate, i_data, i_valid,
    input  o_ready, o_data, o_valid
  );

  modport slave (
    input  i_start, i_rate, i_data, i_valid,
    output o_ready, o_data, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/conv_puncture_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_puncture_encoder : K=7 (133/171) serial encoder, 2/3 and 3/4 puncture |
// | Option macro: CONV_PUNCTURE_EN (undefined -> every rate encodes at 1/2)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv_puncture_encoder (
  input wire                     clk,
  input wire                     rst_n,
  conv_puncture_encoder_if.slave bus
);

  logic [5:0] r_s;
  logic [1:0] r_count;
  logic       r_q0;
  logic       r_q1;

  logic       w_ready;
  logic       w_accept;
  logic       w_a;
  logic       w_b;
  logic       w_keep_a;
  logic       w_keep_b;

  assign w_ready  = (r_count <= 2'd1) && !bus.i_start;
  assign w_accept = bus.i_valid && w_ready;
  assign w_a      = bus.i_data ^ r_s[1] ^ r_s[2] ^ r_s[4] ^ r_s[5];
  assign w_b      = bus.i_data ^ r_s[0] ^ r_s[1] ^ r_s[2] ^ r_s[5];

`ifdef CONV_PUNCTURE_EN
  logic [1:0] r_rate;
  logic [1:0] r_ph;
  logic       w_ph_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate <= 2'b00;
      r_ph   <= 2'd0;
    end else if (bus.i_start) begin
      r_rate <= bus.i_rate;
      r_ph   <= 2'd0;
    end else if (w_accept) begin
      r_ph   <= w_ph_last ? 2'd0 : r_ph + 2'd1;
    end
  end

  // Rate code 11 falls into the default arm and encodes at 1/2.
  always_comb begin
    w_keep_a  = 1'b1;
    w_keep_b  = 1'b1;
    w_ph_last = 1'b1;
    case (r_rate)
      2'b01: begin
        w_ph_last = (r_ph == 2'd1);
        w_keep_b  = (r_ph == 2'd0);
      end
      2'b10: begin
        w_ph_last = (r_ph == 2'd2);
        w_keep_a  = (r_ph != 2'd2);
        w_keep_b  = (r_ph != 2'd1);
      end
      default: ;
    endcase
  end
`else
  logic w_unused_rate;

  assign w_unused_rate = ^bus.i_rate;
  assign w_keep_a      = 1'b1;
  assign w_keep_b      = 1'b1;
`endif

  // An accept only happens with count<=1, and that entry drains on the same
  // edge, so the kept bits always land in an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 6'd0;
      r_count <= 2'd0;
      r_q0    <= 1'b0;
      r_q1    <= 1'b0;
    end else if (bus.i_start) begin
      r_s     <= 6'd0;
      r_count <= 2'd0;
    end else if (w_accept) begin
      r_s     <= {r_s[4:0], bus.i_data};
      r_q0    <= w_keep_a ? w_a : w_b;
      r_q1    <= w_b;
      r_count <= {1'b0, w_keep_a} + {1'b0, w_keep_b};
    end else if (r_count != 2'd0) begin
      r_q0    <= r_q1;
      r_count <= r_count - 2'd1;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = (r_count != 2'd0);
  assign bus.o_data  = (r_count != 2'd0) && r_q0;

endmodule
`default_nettype wire
